vdp_cpu_port: RTL and testbench

//  TMS9918-style CPU register interface for the nouveau VDP at IO 0x80 (data) / 0x81 (control).

---
 rtl/vdp_cpu_port_if.sv | 12 +
 rtl/vdp_cpu_port.sv | 155 +++++++++++++++
 tb/tb_vdp_cpu_port.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_cpu_port_if.sv
// CPU-side IO bus of the VDP register port: qualified read/write ticks, port select and data.
// The IO decoder side is the master; vdp_cpu_port is the slave and drives the read mux.
interface vdp_cpu_port_if;
   logic       wr_tick;
   logic       rd_tick;
   logic       mode;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output wr_tick, rd_tick, mode, din, input dout);
   modport slave  (input wr_tick, rd_tick, mode, din, output dout);
endinterface

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU register port: VRAM pointer, read-ahead buffer, control registers, status flag.
// Optional macro VDP_IRQ_EN enables the registered frame interrupt on int_n (otherwise tied high).
module vdp_cpu_port #(
   parameter int VRAM_AW = 14,
   parameter int NREGS   = 8
) (
   input  logic                 phi,
   input  logic                 reset,
   vdp_cpu_port_if.slave        cpu,
   output logic [VRAM_AW-1:0]   vram_addr,
   output logic [7:0]           vram_wdata,
   output logic                 vram_we,
   output logic                 vram_re,
   input  logic [7:0]           vram_rdata,
   output logic [8*NREGS-1:0]   vdp_regs,
   input  logic                 vblank_tick,
   input  logic [6:0]           coll_5s,
   output logic                 int_n
);

   localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREFETCH,
      S_CAPTURE
   } state_e;

   state_e                 state;
   state_e                 state_nxt;

   logic [VRAM_AW-1:0]     addr;
   logic [7:0]             read_ahead;
   logic [7:0]             tmp;
   logic                   second;
   logic                   f_flag;
   logic                   f_nxt;
   logic [NREGS-1:0][7:0]  regs;

   logic                   rd_ev;
   logic                   ctrl_wr;
   logic                   data_wr;
   logic                   data_rd;
   logic                   stat_rd;
   logic                   reg_wr;
   logic                   addr_set;
   logic                   read_setup;
   logic                   capture;
   logic [13:0]            setup_raw;
   logic [VRAM_AW-1:0]     setup_addr;
   logic [RIDX_W-1:0]      reg_idx;

   // A simultaneous write and read tick is treated as the write alone.
   assign rd_ev      = cpu.rd_tick & ~cpu.wr_tick;
   assign ctrl_wr    = cpu.wr_tick &  cpu.mode;
   assign data_wr    = cpu.wr_tick & ~cpu.mode;
   assign data_rd    = rd_ev & ~cpu.mode;
   assign stat_rd    = rd_ev &  cpu.mode;

   assign reg_wr     = ctrl_wr & second &  cpu.din[7];
   assign addr_set   = ctrl_wr & second & ~cpu.din[7];
   assign read_setup = addr_set & ~cpu.din[6];
   assign reg_idx    = cpu.din[RIDX_W-1:0];
   assign setup_raw  = {cpu.din[5:0], tmp};
   assign setup_addr = VRAM_AW'(setup_raw);

   // Set wins over the clear when vblank and a status read share an edge.
   assign f_nxt      = vblank_tick | (f_flag & ~stat_rd);

   assign cpu.dout   = cpu.mode ? {f_flag, coll_5s} : read_ahead;
   assign vdp_regs   = regs;

   // Prefetch sequencer: issue the VRAM read, then capture its data one edge later.
   always_ff @(negedge phi) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:     if (read_setup || data_rd) state_nxt = S_PREFETCH;
         S_PREFETCH: state_nxt = S_CAPTURE;
         S_CAPTURE:  state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path can leave it unassigned (no latches).
      vram_re = 1'b0;
      capture = 1'b0;
      unique case (state)
         S_PREFETCH: vram_re = 1'b1;
         S_CAPTURE:  capture = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(negedge phi) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so statement order here is irrelevant.
      if (reset) begin
         addr       <= '0;
         read_ahead <= '0;
         tmp        <= '0;
         second     <= 1'b0;
         f_flag     <= 1'b0;
         // NOTE: the register file is a handful of flops that must read 0 after reset, so it is reset; a RAM array would not be.
         regs       <= '0;
         vram_addr  <= '0;
         vram_wdata <= '0;
         vram_we    <= 1'b0;
      end else begin
         vram_we <= data_wr;
         f_flag  <= f_nxt;

         if (ctrl_wr && !second) tmp <= cpu.din;

         if (ctrl_wr)                second <= ~second;
         else if (data_wr || rd_ev)  second <= 1'b0;

         if (reg_wr) regs[reg_idx] <= tmp;

         if (addr_set)                             addr <= setup_addr;
         else if (data_wr || state == S_PREFETCH)  addr <= addr + VRAM_AW'(1);

         // vram_addr holds the old pointer for writes and prefetches while addr moves on.
         if (data_wr) begin
            vram_addr  <= addr;
            vram_wdata <= cpu.din;
         end else if (addr_set) begin
            vram_addr  <= setup_addr;
         end else if (data_rd) begin
            vram_addr  <= addr;
         end

         if (data_wr)      read_ahead <= cpu.din;
         else if (capture) read_ahead <= vram_rdata;
      end
   end

`ifdef VDP_IRQ_EN
   logic ie_nxt;

   assign ie_nxt = (reg_wr && reg_idx == RIDX_W'(1)) ? tmp[5] : regs[1][5];

   always_ff @(negedge phi) begin
      if (reset) int_n <= 1'b1;
      else       int_n <= ~(f_nxt & ie_nxt);
   end
`else
   assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: transaction-level model predicts dout, VRAM writes and prefetches.
`timescale 1ns/1ps
module tb_vdp_cpu_port;
   localparam int AW    = 14;
   localparam int DEPTH = 1 << AW;

   logic           phi = 1'b1;
   logic           reset;
   logic [AW-1:0]  vram_addr;
   logic [7:0]     vram_wdata;
   logic           vram_we;
   logic           vram_re;
   logic [7:0]     vram_rdata;
   logic [63:0]    vdp_regs;
   logic           vblank_tick;
   logic [6:0]     coll_5s;
   logic           int_n;

   vdp_cpu_port_if bus ();

   always #5 phi = ~phi;

   vdp_cpu_port #(.VRAM_AW(AW), .NREGS(8)) dut (
      .phi         (phi),
      .reset       (reset),
      .cpu         (bus),
      .vram_addr   (vram_addr),
      .vram_wdata  (vram_wdata),
      .vram_we     (vram_we),
      .vram_re     (vram_re),
      .vram_rdata  (vram_rdata),
      .vdp_regs    (vdp_regs),
      .vblank_tick (vblank_tick),
      .coll_5s     (coll_5s),
      .int_n       (int_n)
   );

   // External dual-port VRAM, CPU side only.
   logic [7:0]    ram [DEPTH];
   logic          ld_all;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_data;

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 131 + (i >> 7)) ^ 8'h5A;
   endfunction

   always @(negedge phi) begin
      if (ld_all) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= init_byte(i);
      end else if (ld_en) begin
         ram[ld_addr] <= ld_data;
      end else if (vram_we) begin
         ram[vram_addr] <= vram_wdata;
      end
      if (vram_re) vram_rdata <= ram[vram_addr];
   end

   // ---------------- scoreboard ----------------
   typedef enum {EV_RD, EV_WR, EV_RE} ev_e;
   typedef struct {
      ev_e        kind;
      int         addr;
      logic [7:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input ev_e kind, input int addr, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic sb_event(input ev_e kind, input int addr, input logic [7:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL sb_unexpected: got %s addr=%0h data=%0h, expected no event", kind.name(), addr, data);
         return;
      end
      e = exp_q.pop_front();
      check("sb_kind", 64'(kind), 64'(e.kind));
      if (kind == e.kind) begin
         if (kind != EV_RD) check($sformatf("sb_%s_addr", kind.name()), 64'(addr), 64'(e.addr));
         if (kind != EV_RE) check($sformatf("sb_%s_data", kind.name()), 64'(data), 64'(e.data));
      end
   endtask

   // Monitor: sample 2 ns after the quiet (rising) edge, well away from the active falling edge.
   always @(posedge phi) begin
      #2;
      if (bus.rd_tick && !bus.wr_tick) sb_event(EV_RD, 0, bus.dout);
      if (vram_we) sb_event(EV_WR, int'(vram_addr), vram_wdata);
      if (vram_re) sb_event(EV_RE, int'(vram_addr), 8'h00);
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [DEPTH];
   logic [7:0] m_regs  [8];
   int         m_addr;
   logic       m_second;
   logic [7:0] m_tmp;
   logic       m_f;
   logic [7:0] m_ra;

   task automatic m_reset();
      m_addr = 0; m_second = 1'b0; m_tmp = 8'h00; m_f = 1'b0; m_ra = 8'h00;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
   endtask

   task automatic m_prefetch();
      push_ev(EV_RE, m_addr, 8'h00);
      m_ra   = ref_mem[m_addr];
      m_addr = (m_addr + 1) % DEPTH;
   endtask

   task automatic m_ctrl_write(input logic [7:0] d);
      if (!m_second) begin
         m_tmp    = d;
         m_second = 1'b1;
      end else begin
         m_second = 1'b0;
         if (d[7]) begin
            m_regs[d[2:0]] = m_tmp;
         end else begin
            m_addr = int'({d[5:0], m_tmp});
            if (!d[6]) m_prefetch();
         end
      end
   endtask

   task automatic m_data_write(input logic [7:0] d);
      push_ev(EV_WR, m_addr, d);
      ref_mem[m_addr] = d;
      m_ra     = d;
      m_addr   = (m_addr + 1) % DEPTH;
      m_second = 1'b0;
   endtask

   task automatic m_data_read();
      push_ev(EV_RD, 0, m_ra);
      m_prefetch();
      m_second = 1'b0;
   endtask

   function automatic logic exp_int_n();
`ifdef VDP_IRQ_EN
      return ~(m_f & m_regs[1][5]);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [63:0] regs_flat();
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
      return r;
   endfunction

   // ---------------- driver ----------------
   typedef enum {OP_CTRL, OP_DWR, OP_DRD, OP_STAT, OP_VB, OP_BOTH} op_e;

   task automatic op(input op_e k, input logic [7:0] d, input logic vb);
      logic [6:0] coll;
      coll = 7'($urandom);
      @(posedge phi);
      coll_5s     = coll;
      vblank_tick = vb;
      bus.din     = d;
      case (k)
         OP_CTRL: begin bus.wr_tick = 1'b1; bus.mode = 1'b1; m_ctrl_write(d); end
         OP_DWR:  begin bus.wr_tick = 1'b1; bus.mode = 1'b0; m_data_write(d); end
         OP_DRD:  begin bus.rd_tick = 1'b1; bus.mode = 1'b0; m_data_read(); end
         OP_STAT: begin
            bus.rd_tick = 1'b1;
            bus.mode    = 1'b1;
            push_ev(EV_RD, 0, {m_f, coll});
            m_f      = 1'b0;
            m_second = 1'b0;
         end
         OP_BOTH: begin
            bus.wr_tick = 1'b1;
            bus.rd_tick = 1'b1;
            bus.mode    = d[0];
            if (d[0]) m_ctrl_write(d);
            else      m_data_write(d);
         end
         default: ;
      endcase
      if (vb) m_f = 1'b1;
      @(posedge phi);
      bus.wr_tick = 1'b0;
      bus.rd_tick = 1'b0;
      vblank_tick = 1'b0;
      repeat (2) @(posedge phi);
      #2;
      check("int_n", 64'(int_n), 64'(exp_int_n()));
      check("vdp_regs", vdp_regs, regs_flat());
   endtask

   task automatic preload(input int a, input logic [7:0] d);
      @(posedge phi);
      ld_en   = 1'b1;
      ld_addr = AW'(a);
      ld_data = d;
      ref_mem[a] = d;
      @(posedge phi);
      ld_en = 1'b0;
   endtask

   initial begin
      int         r;
      logic [7:0] d;

      reset = 1'b1; ld_all = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = 8'h00;
      bus.wr_tick = 1'b0; bus.rd_tick = 1'b0; bus.mode = 1'b0; bus.din = 8'h00;
      vblank_tick = 1'b0; coll_5s = 7'h00;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
      m_reset();
      repeat (3) @(posedge phi);
      ld_all = 1'b0;
      #2;
      check("rst_int_n", 64'(int_n), 64'd1);
      check("rst_vram_we", 64'(vram_we), 64'd0);
      check("rst_vram_re", 64'(vram_re), 64'd0);
      check("rst_regs", vdp_regs, 64'd0);
      bus.mode = 1'b0; #1;
      check("rst_read_ahead", 64'(bus.dout), 64'h00);
      coll_5s = 7'h55; bus.mode = 1'b1; #1;
      check("rst_status", 64'(bus.dout), 64'h55);
      @(posedge phi);
      reset = 1'b0;

      // Register write leaves the pointer alone and pulses nothing.
      op(OP_CTRL, 8'h34, 1'b0); op(OP_CTRL, 8'h87, 1'b0);
      check("t1_reg7", 64'(vdp_regs[63:56]), 64'h34);
      // Write setup at 0, two data writes, then a third shows the pointer at 2.
      op(OP_CTRL, 8'h00, 1'b0); op(OP_CTRL, 8'h40, 1'b0);
      op(OP_DWR, 8'hAA, 1'b0); op(OP_DWR, 8'h55, 1'b0); op(OP_DWR, 8'h77, 1'b0);
      // Read setup at 0x0100 with prefetch, then two data reads; a write lands at 0x0103.
      preload(16'h0100, 8'h11); preload(16'h0101, 8'h22);
      op(OP_CTRL, 8'h00, 1'b0); op(OP_CTRL, 8'h01, 1'b0);
      op(OP_DRD, 8'h00, 1'b0); op(OP_DRD, 8'h00, 1'b0);
      op(OP_DWR, 8'h33, 1'b0);
      // Pointer wrap on write, then a read shows the pointer at 1.
      op(OP_CTRL, 8'hFF, 1'b0); op(OP_CTRL, 8'h7F, 1'b0);
      op(OP_DWR, 8'h01, 1'b0); op(OP_DWR, 8'h02, 1'b0);
      op(OP_DRD, 8'h00, 1'b0);
      // Prefetch issued at 0x3FFF reads 0x3FFF.
      op(OP_CTRL, 8'hFF, 1'b0); op(OP_CTRL, 8'h3F, 1'b0);
      op(OP_DRD, 8'h00, 1'b0);
      // Frame flag, interrupt enable and the set-wins collision.
      op(OP_CTRL, 8'h20, 1'b0); op(OP_CTRL, 8'h81, 1'b0);
      op(OP_VB, 8'h00, 1'b1);
      op(OP_STAT, 8'h00, 1'b0);
      op(OP_STAT, 8'h00, 1'b0);
      op(OP_STAT, 8'h00, 1'b1);
      op(OP_STAT, 8'h00, 1'b0);
      // A status read resets the control byte phase.
      op(OP_CTRL, 8'h12, 1'b0); op(OP_STAT, 8'h00, 1'b0);
      op(OP_CTRL, 8'h34, 1'b0); op(OP_CTRL, 8'h81, 1'b0);
      check("t6_reg1", 64'(vdp_regs[15:8]), 64'h34);
      // Write and read tick together: the write is taken.
      op(OP_BOTH, 8'h5C, 1'b0);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         d = 8'($urandom);
         case (r)
            0, 1, 2: op(OP_CTRL, d, 1'b0);
            3, 4:    op(OP_DWR, d, 1'b0);
            5, 6:    op(OP_DRD, d, 1'b0);
            7:       op(OP_STAT, d, ($urandom_range(0, 3) == 0));
            8:       op(OP_VB, d, 1'b1);
            default: op(OP_BOTH, d, 1'b0);
         endcase
      end

      // Reset lands on the prefetch edge: the pending capture is discarded.
      @(posedge phi);
      bus.rd_tick = 1'b1; bus.mode = 1'b0;
      m_data_read();
      @(posedge phi);
      bus.rd_tick = 1'b0;
      reset = 1'b1;
      @(posedge phi);
      reset = 1'b0;
      m_reset();
      repeat (3) @(posedge phi);
      #2;
      check("rst_mid_ra", 64'(bus.dout), 64'h00);
      op(OP_DWR, 8'hC3, 1'b0);

      repeat (5) @(posedge phi);
      check("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
